// File: rtl/video_timing_pkg.sv
// Shared 720p raster timing constants, counter widths and the generator control state.
// Sprite and screen modules reuse HCOUNT_W/VCOUNT_W so their coordinate buses match.
package video_timing_pkg;

  localparam int unsigned HCOUNT_W = 11;
  localparam int unsigned VCOUNT_W = 10;
  localparam int unsigned FC_W     = 6;

  localparam int unsigned ACTIVE_H_720P      = 1280;
  localparam int unsigned H_FRONT_PORCH_720P = 110;
  localparam int unsigned H_SYNC_WIDTH_720P  = 40;
  localparam int unsigned H_BACK_PORCH_720P  = 220;
  localparam int unsigned ACTIVE_LINES_720P  = 720;
  localparam int unsigned V_FRONT_PORCH_720P = 5;
  localparam int unsigned V_SYNC_WIDTH_720P  = 5;
  localparam int unsigned V_BACK_PORCH_720P  = 20;
  localparam int unsigned FPS_DEFAULT        = 60;

  localparam int unsigned TOTAL_H_720P = ACTIVE_H_720P + H_FRONT_PORCH_720P +
                                         H_SYNC_WIDTH_720P + H_BACK_PORCH_720P;
  localparam int unsigned TOTAL_V_720P = ACTIVE_LINES_720P + V_FRONT_PORCH_720P +
                                         V_SYNC_WIDTH_720P + V_BACK_PORCH_720P;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sync_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulus counter with enable and synchronous clear; exposes its next value so the
// owner can register flags that line up with the count in the same cycle.
module wrap_counter #(
  parameter int unsigned W       = 8,
  parameter int unsigned MODULUS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // Next-count and wrap decode; >= keeps the count bounded even from a corrupted value.
  always_comb begin
    count_next = count;
    wrap       = 1'b0;
    if (en && (count >= LAST)) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
    if (rst) begin
      count_next = '0;
    end else if (en) begin
      if (count >= LAST) begin
        count_next = '0;
      end else begin
        count_next = count + {{(W-1){1'b0}}, 1'b1};
      end
    end else begin
      count_next = count;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count <= count_next;
  end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel coordinates plus sync, active-draw, new-frame and
// frame count, all registered so every output describes the same pixel.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_H      = ACTIVE_H_720P,
  parameter int unsigned H_FRONT_PORCH = H_FRONT_PORCH_720P,
  parameter int unsigned H_SYNC_WIDTH  = H_SYNC_WIDTH_720P,
  parameter int unsigned H_BACK_PORCH  = H_BACK_PORCH_720P,
  parameter int unsigned ACTIVE_LINES  = ACTIVE_LINES_720P,
  parameter int unsigned V_FRONT_PORCH = V_FRONT_PORCH_720P,
  parameter int unsigned V_SYNC_WIDTH  = V_SYNC_WIDTH_720P,
  parameter int unsigned V_BACK_PORCH  = V_BACK_PORCH_720P,
  parameter int unsigned FPS           = FPS_DEFAULT
) (
  input  logic                clk_pixel_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int unsigned TOTAL_H = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned TOTAL_V = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  // One spare bit so a sync window ending exactly at 2^W still compares correctly.
  localparam logic [HCOUNT_W:0] H_ACT  = (HCOUNT_W+1)'(ACTIVE_H);
  localparam logic [HCOUNT_W:0] HS_BEG = (HCOUNT_W+1)'(ACTIVE_H + H_FRONT_PORCH);
  localparam logic [HCOUNT_W:0] HS_END = (HCOUNT_W+1)'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [VCOUNT_W:0] V_ACT  = (VCOUNT_W+1)'(ACTIVE_LINES);
  localparam logic [VCOUNT_W:0] VS_BEG = (VCOUNT_W+1)'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VCOUNT_W:0] VS_END = (VCOUNT_W+1)'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

  sync_state_t         state_r;
  sync_state_t         state_next_s;
  logic                run_s;
  logic                clr_s;
  logic [HCOUNT_W-1:0] h_next_s;
  logic [VCOUNT_W-1:0] v_next_s;
  logic [FC_W-1:0]     f_next_s;
  logic                h_wrap_s;
  logic                v_wrap_s;
  logic                f_wrap_s;
  logic [HCOUNT_W:0]   h_wide_s;
  logic [VCOUNT_W:0]   v_wide_s;
  logic                hs_next_s;
  logic                vs_next_s;
  logic                ad_next_s;
  logic                nf_next_s;
  logic                unused_s;

  // Control state register.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state: any edge with reset low lands in RUN.
  always_comb begin
    state_next_s = state_r;
    if (rst_in) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_next_s = RUN;
        RUN:     state_next_s = RUN;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Holding the counters clear while IDLE makes the IDLE->RUN edge load pixel (0,0).
  assign run_s = (state_r == RUN);
  assign clr_s = rst_in | ~run_s;

  wrap_counter #(.W(HCOUNT_W), .MODULUS(TOTAL_H)) u_hcount (
    .clk(clk_pixel_in), .rst(clr_s), .en(run_s),
    .count(hcount_out), .count_next(h_next_s), .wrap(h_wrap_s)
  );

  wrap_counter #(.W(VCOUNT_W), .MODULUS(TOTAL_V)) u_vcount (
    .clk(clk_pixel_in), .rst(clr_s), .en(h_wrap_s),
    .count(vcount_out), .count_next(v_next_s), .wrap(v_wrap_s)
  );

  wrap_counter #(.W(FC_W), .MODULUS(FPS)) u_fcount (
    .clk(clk_pixel_in), .rst(clr_s), .en(nf_next_s),
    .count(fc_out), .count_next(f_next_s), .wrap(f_wrap_s)
  );

  assign unused_s = ^{v_wrap_s, f_wrap_s, f_next_s};
  assign h_wide_s = {1'b0, h_next_s};
  assign v_wide_s = {1'b0, v_next_s};

  // Flags decoded from the next coordinates so they register alongside the counters.
  always_comb begin
    hs_next_s = 1'b0;
    vs_next_s = 1'b0;
    ad_next_s = 1'b0;
    nf_next_s = 1'b0;
    if (rst_in) begin
      hs_next_s = 1'b0;
      vs_next_s = 1'b0;
      ad_next_s = 1'b0;
      nf_next_s = 1'b0;
    end else begin
      hs_next_s = (h_wide_s >= HS_BEG) && (h_wide_s < HS_END);
      vs_next_s = (v_wide_s >= VS_BEG) && (v_wide_s < VS_END);
      ad_next_s = (h_wide_s < H_ACT) && (v_wide_s < V_ACT);
      nf_next_s = (h_wide_s == H_ACT) && (v_wide_s == V_ACT);
    end
  end

  // Flag output registers.
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      ad_out <= 1'b0;
      nf_out <= 1'b0;
    end else begin
      hs_out <= hs_next_s;
      vs_out <= vs_next_s;
      ad_out <= ad_next_s;
      nf_out <= nf_next_s;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Scoreboard bench: a 720p instance and a reduced-timing instance checked every cycle
// against an arithmetic model of pixel position since reset release.
module tb_video_sig_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } obs_t;

  // reduced timing for instance B
  localparam int BAH = 8, BHF = 2, BHS = 2, BHB = 2;
  localparam int BAL = 4, BVF = 1, BVS = 1, BVB = 1;
  localparam int BTH = BAH + BHF + BHS + BHB;
  localparam int BTV = BAL + BVF + BVS + BVB;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [10:0] hc_a, hc_b;
  logic [9:0]  vc_a, vc_b;
  logic        hs_a, hs_b, vs_a, vs_b, ad_a, ad_b, nf_a, nf_b;
  logic [5:0]  fc_a, fc_b;

  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;
  bit   rel   = 1'b0;
  obs_t q_a[$];
  obs_t q_b[$];
  bit   run_a = 1'b0, run_b = 1'b0;
  int   pa = 0, pb = 0;

  always #5 clk = ~clk;

  video_sig_gen u_a (
    .clk_pixel_in(clk), .rst_in(rst_a), .hcount_out(hc_a), .vcount_out(vc_a),
    .hs_out(hs_a), .vs_out(vs_a), .ad_out(ad_a), .nf_out(nf_a), .fc_out(fc_a)
  );

  video_sig_gen #(
    .ACTIVE_H(BAH), .H_FRONT_PORCH(BHF), .H_SYNC_WIDTH(BHS), .H_BACK_PORCH(BHB),
    .ACTIVE_LINES(BAL), .V_FRONT_PORCH(BVF), .V_SYNC_WIDTH(BVS), .V_BACK_PORCH(BVB),
    .FPS(60)
  ) u_b (
    .clk_pixel_in(clk), .rst_in(rst_b), .hcount_out(hc_b), .vcount_out(vc_b),
    .hs_out(hs_b), .vs_out(vs_b), .ad_out(ad_b), .nf_out(nf_b), .fc_out(fc_b)
  );

  // p = cycles since the first post-reset pixel; everything follows by division.
  function automatic obs_t model(input int p, input bit run, input int ah, input int hf,
                                 input int hsw, input int hb, input int al, input int vf,
                                 input int vsw, input int vb, input int fps);
    obs_t o;
    int th, tv, per, off, h, v;
    o = '0;
    if (run) begin
      th  = ah + hf + hsw + hb;
      tv  = al + vf + vsw + vb;
      per = th * tv;
      off = al * th + ah;
      h   = p % th;
      v   = (p / th) % tv;
      o.h  = 11'(h);
      o.v  = 10'(v);
      o.ad = (h < ah) && (v < al);
      o.hs = (h >= ah + hf) && (h < ah + hf + hsw);
      o.vs = (v >= al + vf) && (v < al + vf + vsw);
      o.nf = (p >= off) && (((p - off) % per) == 0);
      o.fc = (p >= off) ? 6'((((p - off) / per) + 1) % fps) : 6'd0;
    end
    return o;
  endfunction

  // Drive resets for the next edge, push what each DUT must show after it, then wait.
  task automatic step(input bit ra, input bit rb);
    rst_a = ra;
    rst_b = rb;
    if (ra) run_a = 1'b0;
    else if (!run_a) begin run_a = 1'b1; pa = 0; end
    else pa++;
    if (rb) run_b = 1'b0;
    else if (!run_b) begin run_b = 1'b1; pb = 0; end
    else pb++;
    q_a.push_back(model(pa, run_a, 1280, 110, 40, 220, 720, 5, 5, 20, 60));
    q_b.push_back(model(pb, run_b, BAH, BHF, BHS, BHB, BAL, BVF, BVS, BVB, 60));
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_obs(input string name, input obs_t got, input obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
               name, $time, got.h, got.v, got.hs, got.vs, got.ad, got.nf, got.fc,
               want.h, want.v, want.hs, want.vs, want.ad, want.nf, want.fc);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: every edge each DUT presents a pixel; pop and compare.
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #3;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp_obs("dut_720p", {hc_a, vc_a, hs_a, vs_a, ad_a, nf_a, fc_a}, e);
      end else if (!done) begin
        cmp_int("dut_720p_underflow", 0, 1);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp_obs("dut_small", {hc_b, vc_b, hs_b, vs_b, ad_b, nf_b, fc_b}, e);
      end else if (!done) begin
        cmp_int("dut_small_underflow", 0, 1);
      end
    end
  end

  // Aggregate line/frame statistics over the first uninterrupted run after release.
  initial begin
    int ad_cnt = 0, hs_cnt = 0, hs_first = -1, vs_cnt = 0;
    int nf_cnt = 0, last_nf = -1, gap_err = 0, fc_max = 0;
    wait (rel);
    for (int i = 0; i < 60 * BTH * BTV; i++) begin
      @(posedge clk);
      #3;
      if (i < 1650) begin
        if (ad_a) ad_cnt++;
        if (hs_a) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hc_a);
        end
      end
      if (i == 1650) begin
        cmp_int("line_wrap_h", int'(hc_a), 0);
        cmp_int("line_wrap_v", int'(vc_a), 1);
      end
      if (i < BTH * BTV && vs_b) vs_cnt++;
      if (nf_b) begin
        nf_cnt++;
        if (last_nf >= 0 && (i - last_nf) != BTH * BTV) gap_err++;
        last_nf = i;
      end
      if (int'(fc_b) > fc_max) fc_max = int'(fc_b);
    end
    cmp_int("line_ad_count", ad_cnt, 1280);
    cmp_int("line_hs_count", hs_cnt, 40);
    cmp_int("line_hs_start", hs_first, 1390);
    cmp_int("frame_vs_cycles", vs_cnt, BVS * BTH);
    cmp_int("nf_pulse_count", nf_cnt, 60);
    cmp_int("nf_spacing_errors", gap_err, 0);
    cmp_int("fc_max", fc_max, 59);
    cmp_int("fc_after_60th", int'(fc_b), 0);
  end

  // Stimulus: reset release, long free run, directed mid-frame resets, random resets.
  initial begin
    int hold_a = 0, hold_b = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) step(1'b1, 1'b1);
    rel = 1'b1;
    repeat (60 * BTH * BTV) step(1'b0, 1'b0);
    for (int k = 0; k < 200 && (pb % (BTH * BTV)) != (3 * BTH + 5); k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    for (int k = 0; k < 2000 && (pa % 1650) != 700; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    for (int k = 0; k < 4000; k++) begin
      if (hold_a == 0 && $urandom_range(0, 399) == 0) hold_a = $urandom_range(1, 3);
      if (hold_b == 0 && $urandom_range(0, 29) == 0) hold_b = $urandom_range(1, 3);
      step(hold_a > 0, hold_b > 0);
      if (hold_a > 0) hold_a--;
      if (hold_b > 0) hold_b--;
    end
    #5;
    done = 1'b1;
    cmp_int("queue_drained", q_a.size() + q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
